// File: rtl/game_round_seq.sv
// rtl/game_round_seq.sv - door-game round sequencer bus initiator (optional ROUND_CNT_EN: live round counter and status write)
module game_round_seq #(
  parameter logic [31:0] ADDR_RND   = 32'h0000_0004,
  parameter logic [31:0] ADDR_TUP   = 32'h0000_0008,
  parameter logic [31:0] ADDR_P1    = 32'h0000_000C,
  parameter logic [31:0] ADDR_P2    = 32'h0000_0010,
  parameter logic [31:0] ADDR_L1    = 32'h0000_6000,
  parameter logic [31:0] ADDR_L2    = 32'h0000_7000,
  parameter logic [31:0] ADDR_D1    = 32'h0000_8000,
  parameter logic [31:0] ADDR_D2    = 32'h0000_9000,
  parameter logic [31:0] ADDR_ST    = 32'h0001_0000,
  parameter logic [1:0]  INIT_LIVES = 2'd3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] addr_A,
  output logic [31:0] WD,
  output logic        WE,
  input  logic [31:0] RD,
  output logic        busy,
  output logic        game_over,
  output logic [7:0]  round_cnt
);

  typedef enum logic [3:0] {
    IDLE, RD_RND1, RD_RND2, WR_D1, WR_D2, WR_L1, WR_L2,
    POLL_T, RD_P1, RD_P2, UPD, WAIT_TLOW, WR_ST, OVER
  } state_t;

  state_t     state;
  logic       phase;     // 0: address cycle of a read, 1: sample cycle
  logic       post_upd;  // lives writes belong to a finished round, not game start
  logic [1:0] lives1, lives2;
  logic [1:0] door1, door2;
  logic [1:0] pos1, pos2;
  logic [7:0] rc;
  logic [1:0] rnd_door;
  logic [1:0] lives1_upd, lives2_upd;
  logic       unused_rd;

`ifdef ROUND_CNT_EN
  localparam bit ST_EN = 1'b1;
  assign round_cnt = rc;
`else
  localparam bit ST_EN = 1'b0;
  assign round_cnt = 8'd0;
`endif

  assign unused_rd = ^RD[31:3];

  // Door index from the random register: 1..3 and 4..6 both fold onto 0..2, anything else is door 0
  always_comb begin
    rnd_door = 2'd0;
    case (RD[2:0])
      3'd1, 3'd2, 3'd3: rnd_door = RD[1:0] - 2'd1;
      3'd4, 3'd5, 3'd6: rnd_door = RD[1:0];
      default:          rnd_door = 2'd0;
    endcase
  end

  // Lives after this round: a wrong door costs one life, never going below zero
  always_comb begin
    lives1_upd = lives1;
    lives2_upd = lives2;
    if (pos1 != door1 && lives1 != 2'd0) lives1_upd = lives1 - 2'd1;
    if (pos2 != door2 && lives2 != 2'd0) lives2_upd = lives2 - 2'd1;
  end

  // Round sequencer; bus outputs are loaded on the edge that enters each state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= 1'b0;
      post_upd  <= 1'b0;
      lives1    <= INIT_LIVES;
      lives2    <= INIT_LIVES;
      door1     <= 2'd0;
      door2     <= 2'd0;
      pos1      <= 2'd0;
      pos2      <= 2'd0;
      rc        <= 8'd0;
      addr_A    <= 32'd0;
      WD        <= 32'd0;
      WE        <= 1'b0;
      busy      <= 1'b0;
      game_over <= 1'b0;
    end else begin
      case (state)
        IDLE, OVER: begin
          if (start) begin
            lives1    <= INIT_LIVES;
            lives2    <= INIT_LIVES;
            rc        <= 8'd0;
            post_upd  <= 1'b0;
            busy      <= 1'b1;
            game_over <= 1'b0;
            state     <= WR_L1;
            addr_A    <= ADDR_L1;
            WD        <= {30'b0, INIT_LIVES};
            WE        <= 1'b1;
          end
        end
        WR_L1: begin
          state  <= WR_L2;
          addr_A <= ADDR_L2;
          WD     <= {30'b0, lives2};
          WE     <= 1'b1;
        end
        WR_L2: begin
          if (!post_upd) begin
            state  <= RD_RND1;
            addr_A <= ADDR_RND;
            WD     <= 32'd0;
            WE     <= 1'b0;
            phase  <= 1'b0;
          end else if (ST_EN) begin
            state  <= WR_ST;
            addr_A <= ADDR_ST;
            WD     <= {24'b0, rc};
            WE     <= 1'b1;
          end else begin
            state  <= WAIT_TLOW;
            addr_A <= ADDR_TUP;
            WD     <= 32'd0;
            WE     <= 1'b0;
            phase  <= 1'b0;
          end
        end
        RD_RND1: begin
          if (!phase) begin
            phase <= 1'b1;
          end else begin
            door1  <= rnd_door;
            state  <= WR_D1;
            addr_A <= ADDR_D1;
            WD     <= {30'b0, rnd_door};
            WE     <= 1'b1;
          end
        end
        WR_D1: begin
          state  <= RD_RND2;
          addr_A <= ADDR_RND;
          WD     <= 32'd0;
          WE     <= 1'b0;
          phase  <= 1'b0;
        end
        RD_RND2: begin
          if (!phase) begin
            phase <= 1'b1;
          end else begin
            door2  <= rnd_door;
            state  <= WR_D2;
            addr_A <= ADDR_D2;
            WD     <= {30'b0, rnd_door};
            WE     <= 1'b1;
          end
        end
        WR_D2: begin
          state  <= POLL_T;
          addr_A <= ADDR_TUP;
          WD     <= 32'd0;
          WE     <= 1'b0;
          phase  <= 1'b0;
        end
        POLL_T: begin
          if (!phase) begin
            phase <= 1'b1;
          end else if (RD[0]) begin
            state  <= RD_P1;
            addr_A <= ADDR_P1;
            phase  <= 1'b0;
          end else begin
            phase <= 1'b0;
          end
        end
        RD_P1: begin
          if (!phase) begin
            phase <= 1'b1;
          end else begin
            pos1   <= RD[1:0];
            state  <= RD_P2;
            addr_A <= ADDR_P2;
            phase  <= 1'b0;
          end
        end
        RD_P2: begin
          if (!phase) begin
            phase <= 1'b1;
          end else begin
            pos2   <= RD[1:0];
            state  <= UPD;
            addr_A <= 32'd0;
            WD     <= 32'd0;
            WE     <= 1'b0;
          end
        end
        UPD: begin
          lives1   <= lives1_upd;
          lives2   <= lives2_upd;
          post_upd <= 1'b1;
          if (ST_EN) rc <= rc + 8'd1;
          state    <= WR_L1;
          addr_A   <= ADDR_L1;
          WD       <= {30'b0, lives1_upd};
          WE       <= 1'b1;
        end
        WR_ST: begin
          state  <= WAIT_TLOW;
          addr_A <= ADDR_TUP;
          WD     <= 32'd0;
          WE     <= 1'b0;
          phase  <= 1'b0;
        end
        WAIT_TLOW: begin
          if (!phase) begin
            phase <= 1'b1;
          end else if (RD[0]) begin
            phase <= 1'b0;
          end else if (lives1 == 2'd0 || lives2 == 2'd0) begin
            state     <= OVER;
            addr_A    <= 32'd0;
            busy      <= 1'b0;
            game_over <= 1'b1;
          end else begin
            state  <= RD_RND1;
            addr_A <= ADDR_RND;
            phase  <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          addr_A <= 32'd0;
          WD     <= 32'd0;
          WE     <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_round_seq.sv
// tb/tb_game_round_seq.sv - self-checking bench for game_round_seq with a bus-responder and write-stream model
module tb_game_round_seq;

  localparam logic [31:0] A_RND = 32'h0000_0004;
  localparam logic [31:0] A_TUP = 32'h0000_0008;
  localparam logic [31:0] A_P1  = 32'h0000_000C;
  localparam logic [31:0] A_P2  = 32'h0000_0010;
  localparam logic [31:0] A_L1  = 32'h0000_6000;
  localparam logic [31:0] A_L2  = 32'h0000_7000;
  localparam logic [31:0] A_D1  = 32'h0000_8000;
  localparam logic [31:0] A_D2  = 32'h0000_9000;
  localparam logic [31:0] A_ST  = 32'h0001_0000;
  localparam logic [31:0] GARB  = 32'h5A5A_5A50;

  logic        clk, reset, start;
  logic [31:0] addr_A, WD, RD;
  logic        WE, busy, game_over;
  logic [7:0]  round_cnt;

  logic       tup;
  logic [1:0] p1_pos, p2_pos;
  logic [2:0] rnd_arr [0:63];
  int         rnd_idx = 0;
  int         rnd_wr = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;
  wr_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t_start = 0;
  int last_tup_hi = 0;
  bit lat_armed = 0;
  bit lat6_armed = 0;
  logic [31:0] prev_addr = 32'd0;

  int m_l1, m_l2, m_d1, m_d2, m_round;

  game_round_seq dut (
    .clk(clk), .reset(reset), .start(start),
    .addr_A(addr_A), .WD(WD), .WE(WE), .RD(RD),
    .busy(busy), .game_over(game_over), .round_cnt(round_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Memory-mapped registers the sequencer reads; upper bits carry junk it must ignore
  always_comb begin
    RD = GARB;
    case (addr_A)
      A_RND: RD = GARB | {29'b0, rnd_arr[rnd_idx[5:0]]};
      A_TUP: RD = GARB | {31'b0, tup};
      A_P1:  RD = GARB | {30'b0, p1_pos};
      A_P2:  RD = GARB | {30'b0, p2_pos};
      default: RD = GARB;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int door_of(input int r);
    if (r >= 1 && r <= 3) return r - 1;
    if (r >= 4 && r <= 6) return r - 4;
    return 0;
  endfunction

  function automatic logic [31:0] exp_rc();
`ifdef ROUND_CNT_EN
    return 32'(m_round);
`else
    return 32'd0;
`endif
  endfunction

  task automatic push(input logic [31:0] a, input int d);
    wr_t w;
    w.a = a;
    w.d = 32'(d);
    exp_q.push_back(w);
  endtask

  task automatic model_start();
    m_l1 = 3; m_l2 = 3; m_round = 0;
    push(A_L1, 3);
    push(A_L2, 3);
  endtask

  task automatic model_setup(input int r1, input int r2);
    rnd_arr[rnd_wr[5:0]] = 3'(r1); rnd_wr++;
    rnd_arr[rnd_wr[5:0]] = 3'(r2); rnd_wr++;
    m_d1 = door_of(r1);
    m_d2 = door_of(r2);
    push(A_D1, m_d1);
    push(A_D2, m_d2);
  endtask

  task automatic model_resolve(input int a, input int b);
    if (a != m_d1 && m_l1 > 0) m_l1--;
    if (b != m_d2 && m_l2 > 0) m_l2--;
    m_round = (m_round + 1) % 256;
    push(A_L1, m_l1);
    push(A_L2, m_l2);
`ifdef ROUND_CNT_EN
    push(A_ST, m_round);
`endif
  endtask

  // Per-cycle compare of the bus against the predicted write stream
  always @(negedge clk) begin
    if (prev_addr == A_RND && addr_A != A_RND) rnd_idx++;
    prev_addr = addr_A;
    if (!reset) begin
      if (addr_A == A_TUP && tup) last_tup_hi = cyc;
      if (WE) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write", addr_A, WD);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if (addr_A !== e.a || WD !== e.d) begin
            errors++;
            $display("FAIL bus_write: got addr %h data %h expected addr %h data %h", addr_A, WD, e.a, e.d);
          end
        end
        if (lat_armed && addr_A == A_D1) begin
          lat_armed = 0;
          chk("start_to_d1_cycles", 32'(cyc - t_start), 32'd5);
        end
        if (lat6_armed && addr_A == A_L1) begin
          lat6_armed = 0;
          chk("tup_to_l1_cycles", 32'(cyc - last_tup_hi), 32'd6);
        end
      end else begin
        chk("idle_wd_zero", WD, 32'd0);
      end
    end
  end

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d writes still pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    t_start = cyc;
    lat_armed = 1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic resolve(input int a, input int b);
    @(posedge clk); #1;
    p1_pos = 2'(a);
    p2_pos = 2'(b);
    model_resolve(a, b);
    lat6_armed = 1;
    tup = 1'b1;
    drain(200);
    repeat (50) @(posedge clk);
    chk("hold_busy", {31'b0, busy}, 32'd1);
    chk("round_cnt", {24'b0, round_cnt}, exp_rc());
  endtask

  task automatic next_round(input int r1, input int r2);
    model_setup(r1, r2);
    @(posedge clk); #1;
    tup = 1'b0;
    drain(200);
  endtask

  task automatic end_game();
    int bad;
    bad = 0;
    @(posedge clk); #1;
    tup = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (WE || addr_A != 32'd0 || WD != 32'd0) bad++;
    end
    chk("over_bus_idle", 32'(bad), 32'd0);
    chk("over_game_over", {31'b0, game_over}, 32'd1);
    chk("over_busy", {31'b0, busy}, 32'd0);
    chk("over_round_cnt", {24'b0, round_cnt}, exp_rc());
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit found;
    reset = 1'b1; start = 1'b0; tup = 1'b0; p1_pos = 2'd0; p2_pos = 2'd0;
    for (int i = 0; i < 64; i++) rnd_arr[i] = 3'd0;
    #1;
    chk("rst_addr", addr_A, 32'd0);
    chk("rst_wd", WD, 32'd0);
    chk("rst_we", {31'b0, WE}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_game_over", {31'b0, game_over}, 32'd0);
    chk("rst_round_cnt", {24'b0, round_cnt}, 32'd0);
    repeat (3) @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy", {31'b0, busy}, 32'd0);

    // Game 1: literal setup and first round
    m_l1 = 3; m_l2 = 3; m_round = 0; m_d1 = 1; m_d2 = 1;
    rnd_arr[0] = 3'd5; rnd_arr[1] = 3'd2; rnd_wr = 2;
    push(A_L1, 3); push(A_L2, 3); push(A_D1, 1); push(A_D2, 1);
    do_start();
    drain(100);
    chk("setup_busy", {31'b0, busy}, 32'd1);

    @(posedge clk); #1;
    p1_pos = 2'd1; p2_pos = 2'd0;
    push(A_L1, 3); push(A_L2, 2);
`ifdef ROUND_CNT_EN
    push(A_ST, 1);
`endif
    m_l2 = 2; m_round = 1;
    lat6_armed = 1;
    tup = 1'b1;
    drain(200);
    repeat (50) @(posedge clk);
    chk("r1_busy", {31'b0, busy}, 32'd1);
`ifdef ROUND_CNT_EN
    chk("r1_round_cnt", {24'b0, round_cnt}, 32'd1);
`else
    chk("r1_round_cnt", {24'b0, round_cnt}, 32'd0);
`endif

    next_round(0, 7);
    resolve(3, 3);
    next_round(6, 4);
    resolve(0, 1);
    end_game();

    // Game 2: restart from OVER, stray start while busy, three misses each
    model_start();
    model_setup(3, 1);
    do_start();
    drain(100);
    chk("g2_game_over_cleared", {31'b0, game_over}, 32'd0);
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    chk("start_ignored_busy", {31'b0, busy}, 32'd1);
    resolve(3, 3);
    next_round(4, 6);
    resolve(3, 3);
    next_round(1, 2);
    resolve(3, 3);
    end_game();

    // Game 3: reset lands in the middle of the second door write
    model_start();
    model_setup(6, 5);
    do_start();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (WE && addr_A == A_D2) found = 1;
    end
    chk("d2_write_seen", {31'b0, found}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_we", {31'b0, WE}, 32'd0);
    chk("midrst_addr", addr_A, 32'd0);
    chk("midrst_wd", WD, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_round_cnt", {24'b0, round_cnt}, 32'd0);
    exp_q.delete();
    lat_armed = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_busy", {31'b0, busy}, 32'd0);
    chk("post_rst_addr", addr_A, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_round_seq.md
# game_round_seq

Hardware bus initiator for the door game's memory-mapped data bus; it drives the same addr/WD/WE/RD bus that the data-memory decoder answers. It reads the random-number, time-up and player-position registers, computes the correct doors and remaining lives, and writes them into the video-RAM words. The VGA side then picks them up through the lives and correct-door outputs. It runs the whole round loop without a processor.

## Interface
Parameters:
- ADDR_RND, 32'h0000_0004: random-number register address (bits[2:0] = 1..6)
- ADDR_TUP, 32'h0000_0008: time_up register address (bit0)
- ADDR_P1, 32'h0000_000C: player-1 button/position register address (bits[1:0])
- ADDR_P2, 32'h0000_0010: player-2 position register address (bits[1:0])
- ADDR_L1 / ADDR_L2 / ADDR_D1 / ADDR_D2 / ADDR_ST, 32'h6000 / 7000 / 8000 / 9000 / 10000: video-RAM words for p1_lives, p2_lives, door1, door2, status
- INIT_LIVES, 2'd3: lives loaded at game start

Ports:
- clk, input, 1: system clock
- reset, input, 1: asynchronous, active-high reset
- start, input, 1: single-cycle pulse that begins a game; only honoured in IDLE or OVER
- addr_A, output, 32: bus address
- WD, output, 32: bus write data
- WE, output, 1: bus write strobe
- RD, input, 32: bus read data
- busy, output, 1: high in every state except IDLE and OVER
- game_over, output, 1: high in OVER
- round_cnt, output, 8: completed rounds (see Configuration)

## Operation
- FSM states: IDLE, RD_RND1, RD_RND2, WR_D1, WR_D2, WR_L1, WR_L2, POLL_T, RD_P1, RD_P2, UPD, WAIT_TLOW, WR_ST, OVER.
- Start sequence:
  - start in IDLE or OVER loads lives1 = lives2 = INIT_LIVES and clears round_cnt.
  - The FSM then goes to WR_L1 → WR_L2 → RD_RND1.
- Round setup: RD_RND1 → WR_D1 → RD_RND2 → WR_D2 → POLL_T.
- Door mapping from rnd = RD[2:0]:
  - rnd 1..3 → rnd−1.
  - rnd 4..6 → rnd−4.
  - rnd 0 or 7 → 0.
  - Doors may be equal.
- POLL_T: repeated reads of ADDR_TUP until bit0 = 1, then RD_P1 → RD_P2 → UPD.
- UPD (no bus activity):
  - A player loses a life if pos ≠ door; lives saturate at 0.
  - Both players are evaluated in the same cycle.
  - round_cnt increments, wrapping 255 → 0.
- Then WR_L1 → WR_L2 → WR_ST (if enabled) → WAIT_TLOW.
- WAIT_TLOW: poll ADDR_TUP until bit0 = 0, so one time_up level is counted once. Then:
  - OVER if either lives = 0.
  - RD_RND1 otherwise.
- Write data:
  - Lives writes: WD = {30'b0, livesN}.
  - Door writes: WD = {30'b0, doorN}.
  - Status write: WD = {24'b0, round_cnt}.
- OVER: bus idle; the game_over flag holds until start.

## Timing
- Reset (async, immediate):
  - addr_A = 0, WD = 0, WE = 0, busy = 0, game_over = 0, round_cnt = 0.
  - Lives = INIT_LIVES, doors = 0, state = IDLE.
- Read access = 2 cycles:
  - Cycle 1 presents addr_A with WE = 0.
  - Cycle 2 holds addr_A and samples RD at its end.
  - Each POLL_T/WAIT_TLOW poll is one 2-cycle read.
- Write access = 1 cycle: addr_A, WD and WE = 1 are all registered outputs valid for exactly that cycle.
- WE is never high in two consecutive cycles with different addresses unless both are write states.
- Idle bus: addr_A = 0, WD = 0, WE = 0.
- Cycle counts:
  - start to first WR_D1 strobe = 5 cycles (2 writes + 1 read + 1 state entry).
  - time_up observed to WR_L1 strobe = 6 cycles.
- start while busy: ignored.
- reset mid-write: WE drops asynchronously.

## Configuration
- ROUND_CNT_EN defined:
  - round_cnt is live.
  - WR_ST writes it to ADDR_ST once per round.
- ROUND_CNT_EN undefined:
  - round_cnt is tied to 0.
  - WR_ST is skipped, so UPD goes straight to WR_L1 → WR_L2 → WAIT_TLOW.
  - ADDR_ST is never accessed.

## Test plan
- Reset, then start with rnd = 5 then 2 → bus writes 0x6000←3, 0x7000←3, 0x8000←1, 0x9000←1, with busy = 1.
- time_up = 1 with p1 pos = 1, p2 pos = 0, doors 1/1 → writes 0x6000←3, 0x7000←2; round_cnt = 1 and 0x10000←1 (with ROUND_CNT_EN).
- Hold time_up high for 50 cycles → exactly one life update; no new round setup until time_up = 0.
- Three rounds where both players miss → lives reach 0/0, state OVER, game_over = 1, busy = 0, no further bus traffic. A later start reloads 3/3.
- rnd = 0 and rnd = 7 → door written as 0. rnd = 6 → door 2.
- Assert reset during WR_D2 → WE = 0, addr_A = 0 within the same cycle, and all outputs at reset values.
